// File: rtl/cacheline_adaptor.sv
`default_nettype none
// ============================================================================
// Module      : cacheline_adaptor
// Description : Memory-side responder for the cacheline request port. It
//               accepts one LINE_W-bit line read or write and turns it into a
//               BEATS-beat burst (BEATS = LINE_W/BEAT_W) on the physical
//               memory interface.
//
// Ports       : clk, reset_n        - clock, asynchronous active-low reset
//               read, write         - level line requests, held until resp
//               address, wdata      - line address / line write data
//               resp, rdata         - one-cycle completion, assembled line
//               pmem_read/write     - burst request to memory
//               pmem_addr           - line-aligned burst address
//               pmem_wdata          - current write beat
//               pmem_resp/rdata     - one beat per pmem_resp high cycle
//
// Options     : CACHELINE_ADAPTOR_STATS_EN - adds stat_reads/stat_writes,
//               wrapping 32-bit counters of completed reads and writes.
//
// Revision    : 1.0 - initial release
// ============================================================================
module cacheline_adaptor #(
    parameter int LINE_W = 256,
    parameter int BEAT_W = 64,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              read,
    input  logic              write,
    input  logic [ADDR_W-1:0] address,
    input  logic [LINE_W-1:0] wdata,
    output logic              resp,
    output logic [LINE_W-1:0] rdata,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_addr,
    output logic [BEAT_W-1:0] pmem_wdata,
    input  logic              pmem_resp,
    input  logic [BEAT_W-1:0] pmem_rdata
`ifdef CACHELINE_ADAPTOR_STATS_EN
    ,
    output logic [31:0]       stat_reads,
    output logic [31:0]       stat_writes
`endif
);

    localparam int BEATS = LINE_W / BEAT_W;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int OFF_W = $clog2(LINE_W / 8);

    localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(BEATS - 1);
    // Clears the byte-offset bits so the burst always starts on a line boundary.
    localparam logic [ADDR_W-1:0] ADDR_MASK = {ADDR_W{1'b1}} << OFF_W;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t                        state_q,      state_d;
    logic [CNT_W-1:0]              count_q,      count_d;
    logic [BEATS-1:0][BEAT_W-1:0]  wdata_q,      wdata_d;
    logic [BEATS-1:0][BEAT_W-1:0]  rdata_q,      rdata_d;
    logic [ADDR_W-1:0]             pmem_addr_q,  pmem_addr_d;
    logic [BEAT_W-1:0]             pmem_wdata_q, pmem_wdata_d;
    logic                          pmem_read_q,  pmem_read_d;
    logic                          pmem_write_q, pmem_write_d;
    logic                          resp_q,       resp_d;
    logic [CNT_W-1:0]              count_inc;

`ifdef CACHELINE_ADAPTOR_STATS_EN
    logic                          is_write_q,   is_write_d;
    logic [31:0]                   stat_reads_q, stat_reads_d;
    logic [31:0]                   stat_writes_q, stat_writes_d;
`endif

    assign count_inc = count_q + CNT_W'(1);

    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        wdata_d      = wdata_q;
        rdata_d      = rdata_q;
        pmem_addr_d  = pmem_addr_q;
        pmem_wdata_d = pmem_wdata_q;
        pmem_read_d  = pmem_read_q;
        pmem_write_d = pmem_write_q;
        resp_d       = 1'b0;
`ifdef CACHELINE_ADAPTOR_STATS_EN
        is_write_d    = is_write_q;
        stat_reads_d  = stat_reads_q;
        stat_writes_d = stat_writes_q;
`endif

        case (state_q)
            ST_IDLE: begin
                // Write has priority when both requests are present.
                if (write) begin
                    state_d      = ST_WR;
                    count_d      = '0;
                    pmem_addr_d  = address & ADDR_MASK;
                    wdata_d      = wdata;
                    pmem_wdata_d = wdata[BEAT_W-1:0];
                    pmem_write_d = 1'b1;
`ifdef CACHELINE_ADAPTOR_STATS_EN
                    is_write_d   = 1'b1;
`endif
                end else if (read) begin
                    state_d      = ST_RD;
                    count_d      = '0;
                    pmem_addr_d  = address & ADDR_MASK;
                    pmem_read_d  = 1'b1;
`ifdef CACHELINE_ADAPTOR_STATS_EN
                    is_write_d   = 1'b0;
`endif
                end
            end

            ST_RD: begin
                if (pmem_resp) begin
                    rdata_d[count_q] = pmem_rdata;
                    if (count_q == LAST_BEAT) begin
                        pmem_read_d = 1'b0;
                        count_d     = '0;
                        resp_d      = 1'b1;
                        state_d     = ST_DONE;
                    end else begin
                        count_d     = count_inc;
                    end
                end
            end

            ST_WR: begin
                if (pmem_resp) begin
                    if (count_q == LAST_BEAT) begin
                        pmem_write_d = 1'b0;
                        count_d      = '0;
                        resp_d       = 1'b1;
                        state_d      = ST_DONE;
                    end else begin
                        // Present the next beat as soon as memory takes this one.
                        count_d      = count_inc;
                        pmem_wdata_d = wdata_q[count_inc];
                    end
                end
            end

            ST_DONE: begin
                // Requests still held here belong to the finished transfer.
                state_d = ST_IDLE;
`ifdef CACHELINE_ADAPTOR_STATS_EN
                if (is_write_q) begin
                    stat_writes_d = stat_writes_q + 32'd1;
                end else begin
                    stat_reads_d  = stat_reads_q + 32'd1;
                end
`endif
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            count_q       <= '0;
            wdata_q       <= '0;
            rdata_q       <= '0;
            pmem_addr_q   <= '0;
            pmem_wdata_q  <= '0;
            pmem_read_q   <= 1'b0;
            pmem_write_q  <= 1'b0;
            resp_q        <= 1'b0;
`ifdef CACHELINE_ADAPTOR_STATS_EN
            is_write_q    <= 1'b0;
            stat_reads_q  <= '0;
            stat_writes_q <= '0;
`endif
        end else begin
            state_q       <= state_d;
            count_q       <= count_d;
            wdata_q       <= wdata_d;
            rdata_q       <= rdata_d;
            pmem_addr_q   <= pmem_addr_d;
            pmem_wdata_q  <= pmem_wdata_d;
            pmem_read_q   <= pmem_read_d;
            pmem_write_q  <= pmem_write_d;
            resp_q        <= resp_d;
`ifdef CACHELINE_ADAPTOR_STATS_EN
            is_write_q    <= is_write_d;
            stat_reads_q  <= stat_reads_d;
            stat_writes_q <= stat_writes_d;
`endif
        end
    end

    assign resp       = resp_q;
    assign rdata      = rdata_q;
    assign pmem_read  = pmem_read_q;
    assign pmem_write = pmem_write_q;
    assign pmem_addr  = pmem_addr_q;
    assign pmem_wdata = pmem_wdata_q;

`ifdef CACHELINE_ADAPTOR_STATS_EN
    assign stat_reads  = stat_reads_q;
    assign stat_writes = stat_writes_q;
`endif

endmodule

`default_nettype wire
